// File: rtl/ssd1306_init_seq.sv
// ssd1306_init_seq
//   Command sequencer sitting in front of a byte-level I2C master that talks
//   to an SSD1306 OLED controller.
//   - Waits POWERUP_CYCLES after reset for the panel supply to settle.
//   - Sends the 26-byte init list as one I2C write.
//   - Restarts the whole list after a NACK, up to MAX_RETRY times, with a
//     pause of RETRY_CYCLES between attempts.
//   - Afterwards, forwards single host bytes as 2-byte writes made of a
//     control byte (0x00 = command, 0x40 = GDDRAM data) and the payload.
//
// Ports
//   clk, reset    system clock, synchronous active-high reset
//   tx_addr       7-bit slave address (constant DEV_ADDR)
//   tx_data       byte offered to the I2C master
//   tx_start      offered byte opens a transaction (START + addr + W first)
//   tx_stop       offered byte closes a transaction (STOP after its ACK slot)
//   tx_valid      byte offered; tx_ready = master takes it this cycle
//   ack_valid     one-cycle pulse: ACK slot of the last accepted byte ended
//   ack_nack      with ack_valid: 1 = slave NACKed
//   cmd_data      host payload byte
//   cmd_is_data   0 = command byte, 1 = display RAM data byte
//   cmd_valid     host request; cmd_ready = request taken this cycle
//   init_done     init list completed, sticky until reset
//   init_fail     retries exhausted, sticky until reset
//   busy          a transaction (or retry pause) is in progress
module ssd1306_init_seq #(
   parameter logic [6:0]  DEV_ADDR       = 7'h3C,
   parameter int unsigned POWERUP_CYCLES = 100000,
   parameter int unsigned RETRY_CYCLES   = 10000,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic       clk,
   input  logic       reset,
   output logic [6:0] tx_addr,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic       tx_stop,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic       ack_valid,
   input  logic       ack_nack,
   input  logic [7:0] cmd_data,
   input  logic       cmd_is_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   output logic       init_done,
   output logic       init_fail,
   output logic       busy
);

   typedef enum logic [3:0] {
      S_PWR_WAIT,
      S_INIT_TX,
      S_INIT_ACK,
      S_RETRY_WAIT,
      S_IDLE,
      S_USR_CTRL,
      S_USR_ACK1,
      S_USR_DATA,
      S_USR_ACK2,
      S_FAIL
   } state_t;

   localparam logic [4:0]  ROM_LAST = 5'd25;
   // A zero cycle count behaves like one cycle rather than wrapping around.
   localparam logic [31:0] PWR_LAST = (POWERUP_CYCLES == 0) ? 32'd0 : 32'(POWERUP_CYCLES - 1);
   localparam logic [31:0] RTY_LAST = (RETRY_CYCLES == 0) ? 32'd0 : 32'(RETRY_CYCLES - 1);
   localparam logic [31:0] RTY_MAX  = 32'(MAX_RETRY);

   state_t      state, state_nxt;
   logic [31:0] wait_cnt, wait_cnt_nxt;
   logic [4:0]  idx, idx_nxt;
   logic [31:0] retry_cnt, retry_cnt_nxt;
   logic        done_nxt, fail_nxt;
   logic [7:0]  usr_byte;
   logic        usr_is_data;
   logic        usr_load;

   // Init list; entry 0 is the I2C control byte (command stream follows).
   function automatic logic [7:0] rom_byte(input logic [4:0] i);
      case (i)
         5'd0:    return 8'h00;
         5'd1:    return 8'hAE;
         5'd2:    return 8'hD5;
         5'd3:    return 8'h80;
         5'd4:    return 8'hA8;
         5'd5:    return 8'h3F;
         5'd6:    return 8'hD3;
         5'd7:    return 8'h00;
         5'd8:    return 8'h40;
         5'd9:    return 8'h8D;
         5'd10:   return 8'h14;
         5'd11:   return 8'h20;
         5'd12:   return 8'h00;
         5'd13:   return 8'hA1;
         5'd14:   return 8'hC8;
         5'd15:   return 8'hDA;
         5'd16:   return 8'h12;
         5'd17:   return 8'h81;
         5'd18:   return 8'hCF;
         5'd19:   return 8'hD9;
         5'd20:   return 8'hF1;
         5'd21:   return 8'hDB;
         5'd22:   return 8'h40;
         5'd23:   return 8'hA4;
         5'd24:   return 8'hA6;
         5'd25:   return 8'hAF;
         default: return 8'h00;
      endcase
   endfunction

   assign tx_addr = DEV_ADDR;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_PWR_WAIT;
         wait_cnt  <= 32'd0;
         idx       <= 5'd0;
         retry_cnt <= 32'd0;
         init_done <= 1'b0;
         init_fail <= 1'b0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_cnt_nxt;
         idx       <= idx_nxt;
         retry_cnt <= retry_cnt_nxt;
         init_done <= done_nxt;
         init_fail <= fail_nxt;
      end
   end

   // Host byte holding register; only read after a load, so no reset needed.
   always_ff @(posedge clk) begin
      if (usr_load) begin
         usr_byte    <= cmd_data;
         usr_is_data <= cmd_is_data;
      end
   end

   // Outputs are decoded from the registered state only, so tx_data/start/stop
   // cannot change while an offered byte is stalled by tx_ready = 0.
   always_comb begin
      state_nxt     = state;
      wait_cnt_nxt  = wait_cnt;
      idx_nxt       = idx;
      retry_cnt_nxt = retry_cnt;
      done_nxt      = init_done;
      fail_nxt      = init_fail;
      usr_load      = 1'b0;
      tx_valid      = 1'b0;
      tx_start      = 1'b0;
      tx_stop       = 1'b0;
      tx_data       = 8'h00;
      cmd_ready     = 1'b0;
      busy          = 1'b0;

      case (state)
         S_PWR_WAIT: begin
            if (wait_cnt >= PWR_LAST) begin
               wait_cnt_nxt = 32'd0;
               idx_nxt      = 5'd0;
               state_nxt    = S_INIT_TX;
            end else begin
               wait_cnt_nxt = wait_cnt + 32'd1;
            end
         end

         S_INIT_TX: begin
            busy     = 1'b1;
            tx_valid = 1'b1;
            tx_data  = rom_byte(idx);
            tx_start = (idx == 5'd0);
            tx_stop  = (idx == ROM_LAST);
            if (tx_ready) state_nxt = S_INIT_ACK;
         end

         S_INIT_ACK: begin
            busy = 1'b1;
            if (ack_valid) begin
               if (ack_nack) begin
                  // The master closes the bus with STOP on a NACK by itself.
                  if (retry_cnt < RTY_MAX) begin
                     retry_cnt_nxt = retry_cnt + 32'd1;
                     wait_cnt_nxt  = 32'd0;
                     state_nxt     = S_RETRY_WAIT;
                  end else begin
                     fail_nxt  = 1'b1;
                     state_nxt = S_FAIL;
                  end
               end else if (idx == ROM_LAST) begin
                  done_nxt  = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  idx_nxt   = idx + 5'd1;
                  state_nxt = S_INIT_TX;
               end
            end
         end

         S_RETRY_WAIT: begin
            busy = 1'b1;
            if (wait_cnt >= RTY_LAST) begin
               wait_cnt_nxt = 32'd0;
               idx_nxt      = 5'd0;
               state_nxt    = S_INIT_TX;
            end else begin
               wait_cnt_nxt = wait_cnt + 32'd1;
            end
         end

         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               usr_load  = 1'b1;
               state_nxt = S_USR_CTRL;
            end
         end

         S_USR_CTRL: begin
            busy     = 1'b1;
            tx_valid = 1'b1;
            tx_data  = usr_is_data ? 8'h40 : 8'h00;
            tx_start = 1'b1;
            if (tx_ready) state_nxt = S_USR_ACK1;
         end

         S_USR_ACK1: begin
            busy = 1'b1;
            // A NACK on the control byte drops the host byte silently.
            if (ack_valid) state_nxt = ack_nack ? S_IDLE : S_USR_DATA;
         end

         S_USR_DATA: begin
            busy     = 1'b1;
            tx_valid = 1'b1;
            tx_data  = usr_byte;
            tx_stop  = 1'b1;
            if (tx_ready) state_nxt = S_USR_ACK2;
         end

         S_USR_ACK2: begin
            busy = 1'b1;
            if (ack_valid) state_nxt = S_IDLE;
         end

         S_FAIL: begin
            state_nxt = S_FAIL;
         end

         default: begin
            state_nxt = S_PWR_WAIT;
         end
      endcase
   end

endmodule

// File: tb/tb_ssd1306_init_seq.sv
module tb_ssd1306_init_seq;

   localparam int unsigned PWR  = 4;
   localparam int unsigned RTY  = 8;
   localparam int unsigned MAXR = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] tx_addr;
   logic [7:0] tx_data;
   logic       tx_start, tx_stop, tx_valid;
   logic       tx_ready = 1'b1;
   logic       ack_valid = 1'b0;
   logic       ack_nack = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_is_data = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready, init_done, init_fail, busy;

   always #5 clk = ~clk;

   ssd1306_init_seq #(
      .DEV_ADDR(7'h3C), .POWERUP_CYCLES(PWR), .RETRY_CYCLES(RTY), .MAX_RETRY(MAXR)
   ) dut (
      .clk(clk), .reset(reset), .tx_addr(tx_addr), .tx_data(tx_data),
      .tx_start(tx_start), .tx_stop(tx_stop), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .ack_valid(ack_valid), .ack_nack(ack_nack), .cmd_data(cmd_data),
      .cmd_is_data(cmd_is_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .init_done(init_done), .init_fail(init_fail), .busy(busy)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       start;
      logic       stop;
   } xfer_t;

   typedef struct {
      logic [7:0] data;
      logic       is_data;
      logic       nack_ctrl;
      logic       nack_data;
   } cmd_vec_t;

   logic [7:0] rom [26] = '{8'h00, 8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                            8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81,
                            8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};

   xfer_t got_q[$];
   xfer_t exp_q[$];

   int checks = 0;
   int errors = 0;

   // Master/slave model state, shared between the responder and the test.
   int    ack_cd = 0;
   bit    pend_nack = 0;
   bit    in_init = 1;
   int    nack_idx = -1;
   int    nack_budget = 0;
   bit    usr_nack_ctrl = 0;
   bit    usr_nack_data = 0;
   int    stall_idx = -1;
   int    stall_left = 0;
   int    stall_seen = 0;
   int    stall_bad = 0;
   bit    rand_ready = 0;
   bit    inject_ack = 0;
   int    pos = 0;
   int    cyc = 0;
   int    nack_cyc = 0;
   int    offer_cyc = 0;
   bit    after_nack = 0;
   int    proto_bad = 0;
   bit    prev_stalled = 0;
   xfer_t prev;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Byte-level I2C master + slave: accepts offered bytes, answers each one
   // with an ACK slot 2 cycles later, and watches the handshake rules.
   initial begin : responder
      int cur_pos;
      forever begin
         @(negedge clk);
         cyc++;
         ack_valid = 1'b0;
         ack_nack  = 1'b0;
         if (reset) begin
            ack_cd       = 0;
            pos          = 0;
            prev_stalled = 0;
            after_nack   = 0;
            tx_ready     = 1'b1;
         end else begin
            if (prev_stalled && (!tx_valid || tx_data !== prev.data ||
                                 tx_start !== prev.start || tx_stop !== prev.stop))
               proto_bad++;
            if (ack_cd > 0) begin
               if (tx_valid) proto_bad++;
               ack_cd--;
               if (ack_cd == 0) begin
                  ack_valid = 1'b1;
                  ack_nack  = pend_nack;
                  if (pend_nack) begin
                     nack_cyc   = cyc;
                     after_nack = 1;
                  end
               end
            end else if (inject_ack) begin
               ack_valid  = 1'b1;
               inject_ack = 0;
            end
            cur_pos  = tx_start ? 0 : pos;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid && in_init && cur_pos == stall_idx && stall_left > 0) begin
               tx_ready = 1'b0;
               stall_left--;
               stall_seen++;
               if (tx_data !== rom[stall_idx]) stall_bad++;
            end
            if (after_nack && tx_valid) begin
               offer_cyc  = cyc;
               after_nack = 0;
            end
            prev_stalled = tx_valid && !tx_ready;
            prev         = '{tx_data, tx_start, tx_stop};
            if (tx_valid && tx_ready) begin
               got_q.push_back('{tx_data, tx_start, tx_stop});
               pos    = cur_pos + 1;
               ack_cd = 2;
               if (in_init) begin
                  pend_nack = (cur_pos == nack_idx) && (nack_budget > 0);
                  if (pend_nack) nack_budget--;
               end else begin
                  pend_nack = tx_start ? usr_nack_ctrl : usr_nack_data;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Expected init traffic: each attempt sends the list up to the NACKed
   // byte; after MAX_RETRY restarts a further NACK ends in failure.
   task automatic build_init(input int nidx, input int budget, output bit done, output bit fail);
      int  retries = 0;
      bit  nacked;
      bit  finished = 0;
      done = 0;
      fail = 0;
      while (!finished) begin
         nacked = 0;
         for (int i = 0; i < 26; i++) begin
            exp_q.push_back('{rom[i], 1'(i == 0), 1'(i == 25)});
            if (i == nidx && budget > 0) begin
               budget--;
               nacked = 1;
               break;
            end
         end
         if (!nacked) begin
            done = 1;
            finished = 1;
         end else if (retries < int'(MAXR)) begin
            retries++;
         end else begin
            fail = 1;
            finished = 1;
         end
      end
   endtask

   task automatic compare_stream(input string name);
      int n;
      check({name, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      cmd_valid   = 1'b0;
      in_init     = 1;
      nack_idx    = -1;
      nack_budget = 0;
      stall_idx   = -1;
      stall_left  = 0;
      stall_seen  = 0;
      stall_bad   = 0;
      rand_ready  = 0;
      repeat (3) tick();
      got_q.delete();
      exp_q.delete();
   endtask

   // First byte must appear exactly POWERUP_CYCLES cycles after release.
   task automatic release_pwr(input string name);
      reset = 1'b0;
      for (int k = 1; k <= int'(PWR); k++) begin
         tick();
         check($sformatf("%s_pwr_valid%0d", name, k), 32'(tx_valid), 32'(k == int'(PWR)));
      end
      check({name, "_first_start"}, 32'({tx_start, tx_data}), 32'({1'b1, 8'h00}));
   endtask

   task automatic wait_init(input string name, input bit exp_done, input bit exp_fail);
      bit timed_out = 1;
      for (int n = 0; n < 3000; n++) begin
         if (init_done || init_fail) begin
            timed_out = 0;
            break;
         end
         tick();
      end
      check({name, "_timeout"}, 32'(timed_out), 32'd0);
      check({name, "_done_fail"}, 32'({init_done, init_fail}), 32'({exp_done, exp_fail}));
   endtask

   task automatic run_cmd(input string name, input cmd_vec_t v);
      int busy_low = 0;
      bit timed_out = 1;
      usr_nack_ctrl = v.nack_ctrl;
      usr_nack_data = v.nack_data;
      check({name, "_ready_before"}, 32'(cmd_ready), 32'd1);
      cmd_data    = v.data;
      cmd_is_data = v.is_data;
      cmd_valid   = 1'b1;
      tick();
      cmd_valid = 1'b0;
      check({name, "_ready_pulse_busy"}, 32'({cmd_ready, busy}), 32'({1'b0, 1'b1}));
      for (int n = 0; n < 300; n++) begin
         tick();
         if (cmd_ready) begin
            timed_out = 0;
            break;
         end
         if (!busy) busy_low++;
      end
      check({name, "_timeout"}, 32'(timed_out), 32'd0);
      check({name, "_busy_low"}, 32'(busy_low), 32'd0);
      exp_q.push_back('{v.is_data ? 8'h40 : 8'h00, 1'b1, 1'b0});
      if (!v.nack_ctrl) exp_q.push_back('{v.data, 1'b0, 1'b1});
      compare_stream(name);
   endtask

   initial begin : test
      bit       d, f;
      int       hold_bad;
      bit       timed_out;
      cmd_vec_t vecs [5];
      cmd_vec_t rv;

      vecs[0] = '{8'hAA, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{8'h55, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{8'hF0, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b0};

      // Reset values.
      do_reset();
      check("rst_tx", 32'({tx_valid, tx_start, tx_stop, tx_data}), 32'd0);
      check("rst_flags", 32'({cmd_ready, init_done, init_fail, busy}), 32'd0);
      check("tx_addr", 32'(tx_addr), 32'h3C);

      // Clean init.
      release_pwr("init");
      build_init(-1, 0, d, f);
      wait_init("init", d, f);
      compare_stream("init");
      check("idle_state", 32'({cmd_ready, busy}), 32'({1'b1, 1'b0}));

      // Stray ACK report with nothing outstanding must be ignored.
      inject_ack = 1;
      repeat (3) tick();
      check("stray_ack", 32'({tx_valid, cmd_ready, busy}), 32'({1'b0, 1'b1, 1'b0}));
      got_q.delete();

      // Host command table.
      in_init = 0;
      for (int i = 0; i < 5; i++) run_cmd($sformatf("cmd%0d", i), vecs[i]);

      // Randomized host traffic with random back-pressure and NACKs.
      rand_ready = 1;
      for (int i = 0; i < 20; i++) begin
         rv.data      = 8'($urandom_range(0, 255));
         rv.is_data   = 1'($urandom_range(0, 1));
         rv.nack_ctrl = ($urandom_range(0, 3) == 0);
         rv.nack_data = ($urandom_range(0, 3) == 0);
         repeat ($urandom_range(0, 3)) tick();
         run_cmd($sformatf("rnd%0d", i), rv);
      end

      // Reset while waiting for the ACK slot of index 10.
      do_reset();
      release_pwr("mid");
      timed_out = 1;
      for (int n = 0; n < 500; n++) begin
         if (got_q.size() >= 11) begin
            timed_out = 0;
            break;
         end
         tick();
      end
      check("mid_reach_idx10", 32'(timed_out), 32'd0);
      tick();
      reset = 1'b1;
      tick();
      check("mid_after_reset", 32'({tx_valid, busy, init_done}), 32'd0);
      repeat (2) tick();
      got_q.delete();
      exp_q.delete();
      release_pwr("mid_rerun");
      build_init(-1, 0, d, f);
      wait_init("mid_rerun", d, f);
      compare_stream("mid_rerun");

      // Stall on index 3, NACK on index 5, one retry, then success.
      do_reset();
      stall_idx   = 3;
      stall_left  = 5;
      nack_idx    = 5;
      nack_budget = 1;
      release_pwr("retry");
      build_init(5, 1, d, f);
      wait_init("retry", d, f);
      compare_stream("retry");
      check("stall_cycles", 32'(stall_seen), 32'd5);
      check("stall_data", 32'(stall_bad), 32'd0);
      check("retry_gap", 32'(offer_cyc - nack_cyc), 32'(RTY + 1));

      // NACK on every first byte: MAX_RETRY restarts, then failure.
      do_reset();
      nack_idx    = 0;
      nack_budget = 100;
      release_pwr("fail");
      build_init(0, 100, d, f);
      wait_init("fail", d, f);
      compare_stream("fail");
      cmd_valid = 1'b1;
      hold_bad  = 0;
      repeat (20) begin
         tick();
         if (tx_valid || cmd_ready || busy || !init_fail || init_done) hold_bad++;
      end
      cmd_valid = 1'b0;
      check("fail_terminal", 32'(hold_bad), 32'd0);
      check("fail_no_traffic", 32'(got_q.size()), 32'd0);

      check("protocol", 32'(proto_bad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ssd1306_init_seq.md
Name: ssd1306_init_seq

Overview:
- Upstream command sequencer for the I2C display master.
- After reset it waits for panel power-up, then sends the SSD1306 init command list as a single I2C write transaction, retrying if it gets a NACK.
- It then forwards single host command/data bytes as 2-byte transactions: control byte, then payload.
- It drives the byte-level I2C master through a valid/ready byte handshake and consumes that master's per-byte ACK report.

Parameters:
- DEV_ADDR, 7'h3C, 7-bit slave address (0x78 on the wire with W bit).
- POWERUP_CYCLES, 100000, clk cycles to wait after reset before the first byte.
- RETRY_CYCLES, 10000, clk cycles to wait after a NACK before restarting init.
- MAX_RETRY, 3, number of init restarts allowed before failure.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- tx_addr  out  7  slave address, constant DEV_ADDR
- tx_data  out  8  byte to transmit
- tx_start  out  1  with tx_valid: byte is first of transaction (master emits START+addr+W before it)
- tx_stop  out  1  with tx_valid: byte is last of transaction (master emits STOP after its ACK slot)
- tx_valid  out  1  byte offered
- tx_ready  in  1  master accepts byte
- ack_valid  in  1  1-cycle pulse: ACK slot for last accepted byte finished
- ack_nack  in  1  qualified by ack_valid: 1 = slave NACKed
- cmd_data  in  8  host payload byte
- cmd_is_data  in  1  0 = command (control 0x00), 1 = GDDRAM data (control 0x40)
- cmd_valid  in  1  host request
- cmd_ready  out  1  host request accepted this cycle
- init_done  out  1  init completed OK; sticky until reset
- init_fail  out  1  retries exhausted; sticky until reset
- busy  out  1  transaction in progress

Behaviour:
- Reset values:
  - state = S_PWR_WAIT; wait counter = 0; byte index = 0; retry count = 0.
  - tx_valid = 0, tx_start = 0, tx_stop = 0, tx_data = 0.
  - cmd_ready = 0, init_done = 0, init_fail = 0, busy = 0.
- Reset mid-transaction: state returns to S_PWR_WAIT and tx_valid drops to 0 the next cycle. The master must abort on its own reset; this block does not emit STOP.
- Init ROM, 26 bytes, index 0..25: 00, AE, D5, 80, A8, 3F, D3, 00, 40, 8D, 14, 20, 00, A1, C8, DA, 12, 81, CF, D9, F1, DB, 40, A4, A6, AF.
  - Index 0 is the control byte.
  - tx_start = 1 only at index 0; tx_stop = 1 only at index 25.
- Handshake rules:
  - A byte transfers on a cycle with tx_valid && tx_ready.
  - tx_data, tx_start and tx_stop stay stable while tx_valid = 1 and tx_ready = 0.
  - tx_valid drops the cycle after transfer. At most one byte is outstanding.
  - The next byte is offered no earlier than the cycle after ack_valid.
  - ack_valid arriving while no byte is outstanding is ignored.
- State machine:
  - S_PWR_WAIT: busy = 0. Count to POWERUP_CYCLES-1, then index = 0 and go to S_INIT_TX.
  - S_INIT_TX: busy = 1, tx_valid = 1, tx_data = ROM[index]. On transfer go to S_INIT_ACK.
  - S_INIT_ACK: wait for ack_valid.
    - nack = 1: if retry count < MAX_RETRY, increment it and go to S_RETRY_WAIT; else init_fail = 1 and go to S_FAIL. The master must STOP on NACK itself.
    - ACK at index 25: init_done = 1, go to S_IDLE.
    - ACK otherwise: index + 1, go to S_INIT_TX.
  - S_RETRY_WAIT: busy = 1. Count RETRY_CYCLES, then index = 0 and go to S_INIT_TX.
  - S_IDLE: busy = 0, cmd_ready = 1.
    - On cmd_valid: latch cmd_data and cmd_is_data, cmd_ready pulses for that one cycle, go to S_USR_CTRL.
  - S_USR_CTRL: busy = 1. Offer 0x00 or 0x40 (per latched flag) with tx_start = 1, tx_stop = 0. On transfer go to S_USR_ACK1.
  - S_USR_ACK1: on ack_valid, go to S_USR_DATA if ACK, or to S_IDLE on NACK. The byte is dropped, with no retry and no flag.
  - S_USR_DATA: offer the latched byte with tx_start = 0, tx_stop = 1. On transfer go to S_USR_ACK2.
  - S_USR_ACK2: on ack_valid go to S_IDLE, whether ACK or NACK.
  - S_FAIL: terminal until reset. tx_valid = 0, cmd_ready = 0, busy = 0.
- cmd_ready is 0 in every state except S_IDLE. cmd_valid outside S_IDLE is not consumed; the host holds it.
- Wait counters are 32-bit. POWERUP_CYCLES = 1 means the first byte is offered on the 2nd cycle after reset release.

Test Plan:
- POWERUP_CYCLES = 4, always-ready master that ACKs 2 cycles after each transfer -> exactly 26 transfers, bytes equal the ROM, tx_start only on byte 0x00 at index 0, tx_stop only on 0xAF, init_done = 1, init_fail = 0.
- tx_ready held low 5 cycles on index 3 -> tx_valid stays 1 with tx_data = 0x80 stable; no extra transfer; sequence resumes at index 4.
- NACK on index 5, RETRY_CYCLES = 8 -> no tx_valid for 8 cycles, then restart at index 0 with tx_start = 1; retry count = 1; full sequence then completes.
- MAX_RETRY = 2, NACK on every index 0 -> 3 attempts total, then init_fail = 1, init_done = 0; tx_valid and cmd_ready stay 0 afterwards.
- After init, cmd_valid with cmd_data = 0xAA, cmd_is_data = 1 -> one-cycle cmd_ready; transfers 0x40 (start), then 0xAA (stop); busy high throughout; returns to S_IDLE.
- reset asserted while in S_INIT_ACK at index 10 -> next cycle tx_valid = 0, busy = 0, init_done = 0; after release the power-up wait repeats and init restarts from index 0.
